// File: rtl/condicionador_botoes_pkg.sv
// ============================================================================
// Module  : condicionador_botoes_pkg
// Brief   : Shared FSM states, counter width and helper for the button conditioner.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package condicionador_botoes_pkg;

    localparam int c_LARGURA_CONTADOR = 16;
    localparam int c_NUM_CANAIS       = 5;

    typedef enum logic [1:0] {
        ESPERA_SOLTAR = 2'b00,
        LIVRE         = 2'b01,
        PRESSIONADO   = 2'b10
    } estado_t;

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic mais_de_um(input logic [3:0] i_vetor);
        return (i_vetor & (i_vetor - 4'd1)) != 4'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/condicionador_botoes_filtro_debounce.sv
// ============================================================================
// Module  : filtro_debounce
// Brief   : Single-channel debouncer: optional 2-flop synchronizer
//           (CONDICIONADOR_SINCRONIZADOR_EN), 16-bit counter, stable level.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module filtro_debounce
    import condicionador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_bruto,
    output logic o_estavel,
    output logic o_pendente
);

    localparam logic [c_LARGURA_CONTADOR-1:0] c_LIMITE =
        c_LARGURA_CONTADOR'(DEBOUNCE_CICLOS - 1);

    logic                          w_amostra;
    logic                          r_estavel;
    logic [c_LARGURA_CONTADOR-1:0] r_contador;

`ifdef CONDICIONADOR_SINCRONIZADOR_EN
    logic       r_sinc1;
    logic       r_sinc2;
    logic [1:0] r_aquecido;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sinc1    <= 1'b0;
            r_sinc2    <= 1'b0;
            r_aquecido <= 2'b00;
        end else begin
            r_sinc1    <= i_bruto;
            r_sinc2    <= r_sinc1;
            r_aquecido <= {r_aquecido[0], 1'b1};
        end
    end

    assign w_amostra = r_sinc2;
    // Until the synchronizer has refilled after reset its contents say nothing
    // about the real input, so the channel reports itself as unsettled.
    assign o_pendente = (r_sinc1 != r_estavel) | (r_sinc2 != r_estavel) | ~r_aquecido[1];
`else
    assign w_amostra  = i_bruto;
    assign o_pendente = (w_amostra != r_estavel);
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estavel  <= 1'b0;
            r_contador <= '0;
        end else if (w_amostra == r_estavel) begin
            r_contador <= '0;
        end else if (r_contador == c_LIMITE) begin
            r_estavel  <= w_amostra;
            r_contador <= '0;
        end else begin
            r_contador <= r_contador + 1'b1;
        end
    end

    assign o_estavel = r_estavel;

endmodule

`default_nettype wire

// File: rtl/condicionador_botoes.sv
// ============================================================================
// Module  : condicionador_botoes
// Brief   : Debounces 4 game buttons and a start button, produces play/start
//           pulses. Optional input synchronizer: CONDICIONADOR_SINCRONIZADOR_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes_brutos,
    input  logic       iniciar_bruto,
    output logic [3:0] botoes,
    output logic       iniciar,
    output logic       jogada_pulso,
    output logic [3:0] jogada_codigo,
    output logic       db_multipla,
    output logic [1:0] db_estado
);

    logic [c_NUM_CANAIS-1:0] w_brutos;
    logic [c_NUM_CANAIS-1:0] w_estavel;
    logic [c_NUM_CANAIS-1:0] w_pendente;
    logic [3:0]              w_botoes;

    estado_t    r_estado;
    logic       r_pulso;
    logic [3:0] r_codigo;
    logic       r_multipla;
    logic       r_ini_anterior;
    logic       r_ini_armado;
    logic       r_iniciar;

    assign w_brutos = {iniciar_bruto, botoes_brutos};

    for (genvar gi = 0; gi < c_NUM_CANAIS; gi++) begin : g_canal
        filtro_debounce #(
            .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
        ) u_filtro (
            .clock      (clock),
            .reset      (reset),
            .i_bruto    (w_brutos[gi]),
            .o_estavel  (w_estavel[gi]),
            .o_pendente (w_pendente[gi])
        );
    end

    assign w_botoes = w_estavel[3:0];

    // Leaving ESPERA_SOLTAR also needs the raw side quiet, otherwise a button
    // held through reset would look released before its filter catches up.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado   <= ESPERA_SOLTAR;
            r_pulso    <= 1'b0;
            r_codigo   <= 4'd0;
            r_multipla <= 1'b0;
        end else begin
            r_pulso <= 1'b0;
            case (r_estado)
                ESPERA_SOLTAR: begin
                    if ((w_botoes == 4'd0) && (w_pendente[3:0] == 4'd0)) begin
                        r_estado <= LIVRE;
                    end
                end
                LIVRE: begin
                    if (w_botoes != 4'd0) begin
                        r_estado   <= PRESSIONADO;
                        r_pulso    <= 1'b1;
                        r_codigo   <= w_botoes;
                        r_multipla <= mais_de_um(w_botoes);
                    end
                end
                PRESSIONADO: begin
                    if (w_botoes == 4'd0) begin
                        r_estado <= LIVRE;
                    end
                end
                default: begin
                    r_estado <= ESPERA_SOLTAR;
                end
            endcase
        end
    end

    // Start pulses are armed only once the start channel has been seen released,
    // so a start button held through reset stays silent until pressed again.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ini_anterior <= 1'b0;
            r_ini_armado   <= 1'b0;
            r_iniciar      <= 1'b0;
        end else begin
            r_ini_anterior <= w_estavel[4];
            if (!w_estavel[4] && !w_pendente[4]) begin
                r_ini_armado <= 1'b1;
            end
            r_iniciar <= w_estavel[4] & ~r_ini_anterior & r_ini_armado;
        end
    end

    assign botoes        = w_botoes;
    assign iniciar       = r_iniciar;
    assign jogada_pulso  = r_pulso;
    assign jogada_codigo = r_codigo;
    assign db_multipla   = r_multipla;
    assign db_estado     = r_estado;

endmodule

`default_nettype wire

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CICLOS, default 50000, the number of consecutive differing samples needed to accept a new input level; legal range 2..65535.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 The block SHALL have port botoes_brutos, input, 4 bits: raw game push-buttons, active-high, asynchronous to clock.
REQ-005 The block SHALL have port iniciar_bruto, input, 1 bit: raw start button, active-high, asynchronous.
REQ-006 The block SHALL have port botoes, output, 4 bits: debounced button levels, feeding the game top-level botoes input.
REQ-007 The block SHALL have port iniciar, output, 1 bit: one-cycle pulse on each accepted press of the start button.
REQ-008 The block SHALL have port jogada_pulso, output, 1 bit: one-cycle pulse when a new play is accepted.
REQ-009 The block SHALL have port jogada_codigo, output, 4 bits: debounced button vector captured with jogada_pulso; held until the next pulse.
REQ-010 The block SHALL have port db_multipla, output, 1 bit: high while the held jogada_codigo has more than one bit set.
REQ-011 The block SHALL have port db_estado, output, 2 bits: current FSM state encoding.

Function
REQ-012 The block SHALL filter each of the 5 channels independently with a 16-bit counter; counter clears when sample equals stable level, otherwise increments.
REQ-013 The block SHALL update a channel's stable level, and clear its counter, on the edge where the counter equals DEBOUNCE_CICLOS-1 and the sample still differs; the new level is visible the following cycle.
REQ-014 The block SHALL discard any glitch shorter than DEBOUNCE_CICLOS cycles: stable level and outputs unchanged.
REQ-015 The block SHALL assert iniciar for exactly one cycle, the cycle after the start channel's stable level goes 0->1; no pulse on release.
REQ-016 The block SHALL implement the FSM states ESPERA_SOLTAR (00), LIVRE (01) and PRESSIONADO (10); encoding 11 is unused and SHALL return to ESPERA_SOLTAR.
REQ-017 In ESPERA_SOLTAR, when the debounced botoes vector equals 0, the FSM SHALL move to LIVRE.
REQ-018 In LIVRE, when the debounced botoes vector is non-zero, the FSM SHALL move to PRESSIONADO, assert jogada_pulso for that single transition cycle, and load jogada_codigo with the vector.
REQ-019 In PRESSIONADO the FSM SHALL ignore further presses; when the debounced botoes vector equals 0, it SHALL move to LIVRE with no pulse.
REQ-020 If several channels become stable in the same cycle, the block SHALL capture the whole vector and set db_multipla; no priority encoding is applied.
REQ-021 A second button pressed while another is held SHALL NOT produce a pulse; the next pulse requires full release first.
REQ-022 The start-button and game-button paths SHALL be independent; simultaneous events SHALL produce both pulses in the same cycle.

Reset
REQ-023 While reset=0 at a clock edge, the block SHALL clear all counters and stable levels to 0, force the FSM to ESPERA_SOLTAR, and drive botoes, iniciar, jogada_pulso, jogada_codigo and db_multipla to 0 and db_estado to 00.
REQ-024 A button held through reset release SHALL NOT generate a pulse until it has been released and pressed again.
REQ-025 Reset asserted mid-debounce or mid-press SHALL abort the operation with no pulse emitted.

Configuration
REQ-026 With macro CONDICIONADOR_SINCRONIZADOR_EN defined, each raw input SHALL pass through a 2-flop synchronizer (also cleared by reset) before filtering, adding 2 cycles of latency.
REQ-027 Without CONDICIONADOR_SINCRONIZADOR_EN, raw inputs SHALL be sampled directly by the filters, and all latencies are 2 cycles shorter.

Structure
REQ-028 The shared package SHALL hold the FSM state constants (ESPERA_SOLTAR, LIVRE, PRESSIONADO) and the counter width constant (16).
REQ-029 One sub-module, filtro_debounce (single channel: optional synchronizer, counter, stable level), SHALL be instantiated 5 times.

Verification
REQ-030 The bench SHALL use DEBOUNCE_CICLOS=4 with the macro undefined for scenarios 031-035 and defined for scenario 036.
REQ-031 Scenario: botoes_brutos=0010 held 10 cycles from LIVRE -> botoes=0010 after 4 edges; jogada_pulso high for 1 cycle; jogada_codigo=0010; db_estado=10.
REQ-032 Scenario: 3-cycle glitch of 1000 -> botoes stays 0000; no pulse.
REQ-033 Scenario: 0001 held, then 0101 added, then all released -> one pulse only; FSM returns to 01 after release debounces.
REQ-034 Scenario: 0110 arrives in a single edge -> jogada_codigo=0110; db_multipla=1.
REQ-035 Scenario: button held across reset release -> FSM stays 00 and no pulse; after release then press -> one pulse.
REQ-036 Scenario: iniciar_bruto high 8 cycles -> iniciar pulses once, 1 cycle long; with the macro defined the pulse occurs exactly 2 cycles later.
